// File: rtl/mem_bus_arb.sv
// Single-master arbiter sharing one cyc/stb/ack bus port between instruction fetch
// and data load/store, with data-streak fairness and a per-access ack timeout.
module mem_bus_arb #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_gnt,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat_o,
  output logic [3:0]  sel,
  input  logic [31:0] dat_i,
  input  logic        ack_in
);

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DONE} state_e;

  state_e        state_q;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q;
  logic          own_i_q, flush_q, rerr_q;
  logic [31:0]   rbuf_q;

  logic          if_gnt_q, if_ack_q, d_gnt_q, d_ack_q, err_q;
  logic          cyc_q, stb_q, we_q;
  logic [31:0]   if_rdata_q, d_rdata_q, adr_q, dat_o_q;
  logic [3:0]    sel_q;

  logic          if_req_eff, at_max, fetch_win, data_win, tmo_hit;

  // A flush in IDLE masks the fetch request so a stale fetch cannot win the bus.
  always_comb begin
    if_req_eff = if_req & ~if_flush;
    at_max     = (streak_q == SW'(MAX_D_STREAK));
    fetch_win  = if_req_eff && (!d_req || at_max);
    data_win   = d_req && !fetch_win;
    tmo_hit    = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
    streak_d   = streak_q;
    if (fetch_win)
      streak_d = '0;
    else if (data_win)
      streak_d = if_req_eff ? (at_max ? streak_q : streak_q + 1'b1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      tmo_q      <= '0;
      own_i_q    <= 1'b0;
      flush_q    <= 1'b0;
      rerr_q     <= 1'b0;
      rbuf_q     <= '0;
      if_gnt_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      adr_q      <= '0;
      dat_o_q    <= '0;
      sel_q      <= '0;
    end else begin
      if_gnt_q <= 1'b0;
      d_gnt_q  <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          streak_q <= streak_d;
          tmo_q    <= '0;
          flush_q  <= 1'b0;
          if (fetch_win) begin
            adr_q    <= if_addr;
            we_q     <= 1'b0;
            sel_q    <= 4'hF;
            dat_o_q  <= '0;
            if_gnt_q <= 1'b1;
            own_i_q  <= 1'b1;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            state_q  <= BUS_I;
          end else if (data_win) begin
            adr_q    <= d_addr;
            we_q     <= d_we;
            sel_q    <= d_sel;
            dat_o_q  <= d_wdata;
            d_gnt_q  <= 1'b1;
            own_i_q  <= 1'b0;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            state_q  <= BUS_D;
          end
        end
        BUS_I, BUS_D: begin
          if (state_q == BUS_I && if_flush)
            flush_q <= 1'b1;
          // Ack has priority over a timeout landing in the same cycle.
          if (ack_in) begin
            rbuf_q  <= dat_i;
            rerr_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= DONE;
          end else if (tmo_hit) begin
            rbuf_q  <= '0;
            rerr_q  <= 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= DONE;
          end else if (TIMEOUT != 0) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (own_i_q) begin
            if (!(flush_q || if_flush)) begin
              if_ack_q   <= 1'b1;
              err_q      <= rerr_q;
              if_rdata_q <= rbuf_q;
            end
          end else begin
            d_ack_q <= 1'b1;
            err_q   <= rerr_q;
            if (!we_q || rerr_q)
              d_rdata_q <= rbuf_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt   = if_gnt_q;
  assign if_ack   = if_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_gnt    = d_gnt_q;
  assign d_ack    = d_ack_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;
  assign cyc      = cyc_q;
  assign stb      = stb_q;
  assign we       = we_q;
  assign adr      = adr_q;
  assign dat_o    = dat_o_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Self-checking bench for mem_bus_arb: directed scenarios plus randomized rounds
// checked against a transaction-level model of the arbitration and completion rules.
module tb_mem_bus_arb;

  localparam int MAX_D = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_sel = '0;
  logic        d_gnt, d_ack;
  logic [31:0] d_rdata;
  logic        err, cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic [31:0] dat_i = '0;
  logic        ack_in = 1'b0;

  int compared = 0;
  int mismatched = 0;

  // Model state: pending requests with their held fields, streak and expected rdata.
  bit          pendI = 0, pendD = 0;
  logic [31:0] curIAddr = '0, curDAddr = '0, curDWdata = '0;
  logic        curDWe = 1'b0;
  logic [3:0]  curDSel = '0;
  int          dStreak = 0;
  logic [31:0] expIf = '0, expD = '0;

  mem_bus_arb #(.MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .err(err), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_o(dat_o), .sel(sel),
    .dat_i(dat_i), .ack_in(ack_in)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    if_req  = pendI;
    if_addr = curIAddr;
    d_req   = pendD;
    d_we    = curDWe;
    d_addr  = curDAddr;
    d_wdata = curDWdata;
    d_sel   = curDSel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_cyc"}, cyc, 0);
    checkOutput({pfx, "_stb"}, stb, 0);
    checkOutput({pfx, "_we"}, we, 0);
    checkOutput({pfx, "_adr"}, adr, 0);
    checkOutput({pfx, "_dat_o"}, dat_o, 0);
    checkOutput({pfx, "_sel"}, sel, 0);
    checkOutput({pfx, "_if_gnt"}, if_gnt, 0);
    checkOutput({pfx, "_d_gnt"}, d_gnt, 0);
    checkOutput({pfx, "_if_ack"}, if_ack, 0);
    checkOutput({pfx, "_d_ack"}, d_ack, 0);
    checkOutput({pfx, "_err"}, err, 0);
    checkOutput({pfx, "_if_rdata"}, if_rdata, 0);
    checkOutput({pfx, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    pendI = 0; pendD = 0; dStreak = 0; expIf = '0; expD = '0;
    applyStimulus();
    if_flush = 1'b0; ack_in = 1'b0;
    tick(); tick();
    checkAllZero("reset");
    rst = 1'b0;
  endtask

  // One arbitration + bus access + completion. Entered and left in an IDLE cycle.
  // delay = bus cycle index of ack_in; delay >= TMO means the access times out.
  task automatic runRound(input bit wantI, input bit wantD, input int delay,
                          input bit doFlush, input logic [31:0] rd, output bit gotI);
    bit fetchWins, timedOut, ackI, ackD;
    int lastCyc;
    logic [31:0] holdAdr;
    if (wantI && !pendI) begin
      pendI = 1; curIAddr = $urandom & 32'hFFFF_FFFC;
    end
    if (wantD && !pendD) begin
      pendD = 1; curDWe = 1'($urandom_range(0, 1)); curDAddr = $urandom;
      curDWdata = $urandom; curDSel = 4'($urandom_range(1, 15));
    end
    applyStimulus();
    if_flush = 1'b0; ack_in = 1'b0;
    fetchWins = pendI && (!pendD || dStreak == MAX_D);
    if (fetchWins) dStreak = 0;
    else if (pendI) dStreak = (dStreak < MAX_D) ? dStreak + 1 : MAX_D;
    else dStreak = 0;
    tick();
    gotI = if_gnt;
    checkOutput("if_gnt", if_gnt, fetchWins);
    checkOutput("d_gnt", d_gnt, !fetchWins);
    checkOutput("cyc_up", cyc, 1);
    checkOutput("stb_up", stb, 1);
    if (fetchWins) begin
      checkOutput("fetch_adr", adr, curIAddr);
      checkOutput("fetch_we", we, 0);
      checkOutput("fetch_sel", sel, 4'hF);
      pendI = 0;
    end else begin
      checkOutput("data_adr", adr, curDAddr);
      checkOutput("data_we", we, curDWe);
      checkOutput("data_sel", sel, curDSel);
      checkOutput("data_dat_o", dat_o, curDWdata);
      pendD = 0;
    end
    holdAdr = fetchWins ? curIAddr : curDAddr;
    applyStimulus();
    timedOut = delay > TMO - 1;
    lastCyc  = timedOut ? TMO - 1 : delay;
    for (int i = 0; i <= lastCyc; i++) begin
      ack_in   = (i == delay);
      dat_i    = (i == delay) ? rd : $urandom;
      if_flush = doFlush && (i == 0);
      tick();
      if (i == 0) checkOutput("gnt_pulse", {if_gnt, d_gnt}, 0);
      if (i < lastCyc) begin
        checkOutput("cyc_hold", cyc, 1);
        checkOutput("adr_hold", adr, holdAdr);
      end
    end
    ack_in = 1'b0; if_flush = 1'b0;
    checkOutput("cyc_drop", {cyc, stb}, 0);
    checkOutput("ack_early", {if_ack, d_ack}, 0);
    tick();
    ackI = fetchWins && !doFlush;
    ackD = !fetchWins;
    if (ackI) expIf = timedOut ? 32'h0 : rd;
    if (ackD && (timedOut || !curDWe)) expD = timedOut ? 32'h0 : rd;
    checkOutput("if_ack", if_ack, ackI);
    checkOutput("d_ack", d_ack, ackD);
    checkOutput("err", err, timedOut);
    checkOutput("if_rdata", if_rdata, expIf);
    checkOutput("d_rdata", d_rdata, expD);
  endtask

  initial begin
    bit g;
    logic [9:0] pat;
    applyReset();

    // Fetch only at 0x100
    pendI = 1; curIAddr = 32'h100;
    runRound(1, 0, 0, 0, 32'h0050_0093, g);
    checkOutput("fetch_rdata_const", if_rdata, 32'h0050_0093);

    // Load then store: store must leave d_rdata untouched
    pendD = 1; curDWe = 0; curDAddr = 32'h1000; curDWdata = 0; curDSel = 4'hF;
    runRound(0, 1, 1, 0, 32'h1234_5678, g);
    pendD = 1; curDWe = 1; curDAddr = 32'h2000; curDWdata = 32'hDEAD_BEEF; curDSel = 4'b0011;
    runRound(0, 1, 0, 0, 32'hFFFF_FFFF, g);
    checkOutput("store_keeps_rdata", d_rdata, 32'h1234_5678);

    // Timeout abort, then ack exactly in the last allowed cycle
    pendD = 1; curDWe = 0; curDAddr = 32'h3000; curDSel = 4'hF;
    runRound(0, 1, 100, 0, 32'hAAAA_5555, g);
    checkOutput("timeout_rdata", d_rdata, 0);
    pendD = 1; curDWe = 0; curDAddr = 32'h3004; curDSel = 4'hF;
    runRound(0, 1, TMO - 1, 0, 32'h0BAD_CAFE, g);
    checkOutput("late_ack_rdata", d_rdata, 32'h0BAD_CAFE);

    // Flush during BUS_I, then a normal fetch
    runRound(1, 0, 2, 1, 32'h1111_2222, g);
    checkOutput("flush_keeps_rdata", if_rdata, 32'h0050_0093);
    runRound(1, 0, 0, 0, 32'h3333_4444, g);

    // Flush in IDLE masks the request for that cycle
    pendI = 1; curIAddr = 32'h400;
    applyStimulus();
    if_flush = 1'b1;
    tick();
    checkOutput("idle_flush_gnt", if_gnt, 0);
    checkOutput("idle_flush_cyc", cyc, 0);
    if_flush = 1'b0;
    runRound(1, 0, 0, 0, 32'h5555_6666, g);

    // ack_in while idle is ignored
    ack_in = 1'b1; dat_i = 32'h7777_8888;
    tick();
    ack_in = 1'b0;
    checkOutput("idle_ack", {if_ack, d_ack, err, cyc}, 0);

    // Contention from a clean streak: D,D,D,D,I repeating
    applyReset();
    pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      runRound(1, 1, 0, 0, $urandom, g);
      checkOutput("contention_order", g, pat[i]);
    end

    // Randomized rounds
    for (int i = 0; i < 40; i++) begin
      bit wi, wd;
      wi = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if (!wi && !wd && !pendI && !pendD) wd = 1;
      runRound(wi, wd, $urandom_range(0, 3), ($urandom_range(0, 5) == 0), $urandom, g);
    end

    // Reset in the middle of a data access
    applyReset();
    pendD = 1; curDWe = 0; curDAddr = 32'h5000; curDWdata = 0; curDSel = 4'hF;
    applyStimulus();
    tick();
    checkOutput("rst_mid_gnt", d_gnt, 1);
    checkOutput("rst_mid_cyc", cyc, 1);
    pendD = 0;
    applyStimulus();
    rst = 1'b1;
    tick();
    checkAllZero("rst_mid");
    rst = 1'b0;
    tick();
    checkOutput("rst_mid_no_ack", {d_ack, if_ack, cyc}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Single-master arbiter in front of the CPU's memory bus.
- Shares one cyc/stb/ack bus port between two requesters: instruction fetch (the PC/fetch block) and data load/store.
- Sequences each transaction, enforces fairness so fetch is not starved, and bounds every access with a timeout.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is pending; then fetch must win.
- TIMEOUT, 16: cycles in a bus state without ack before the access is aborted. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch address
- if_flush  in  1  discard the in-flight fetch result
- if_gnt  out  1  one-cycle pulse: fetch request latched
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_sel  in  4  byte enables
- d_gnt  out  1  one-cycle pulse: data request latched
- d_ack  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load data
- err  out  1  valid with if_ack/d_ack; 1 = timeout abort
- cyc  out  1  bus cycle
- stb  out  1  bus strobe
- we  out  1  bus write enable
- adr  out  32  bus address
- dat_o  out  32  bus write data
- sel  out  4  bus byte select
- dat_i  in  32  bus read data
- ack_in  in  1  bus acknowledge

Interface (already decided): one clock, clk; reset rst, synchronous, active-high.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, including rdata registers, err, streak counter and timeout counter.
  - Reset mid-transaction: cyc/stb fall at that edge; no ack pulse is generated.
- States: IDLE, BUS_I, BUS_D, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select a winner, latch its addr/we/wdata/sel into the bus registers and pulse its gnt in the same cycle.
  - Next state BUS_I or BUS_D; cyc=stb=1 from the next cycle.
  - A fetch always drives we=0 and sel=4'hF.
- Priority:
  - Data wins over fetch, except when d_streak == MAX_D_STREAK with if_req high; then fetch wins and d_streak clears.
  - A data grant with if_req high increments d_streak (saturating).
  - A data grant with if_req low, or any fetch grant, clears d_streak.
- BUS_x:
  - cyc, stb, we, adr, dat_o and sel hold stable.
  - Timeout counter increments each cycle.
  - ack_in=1: capture dat_i into the requester's rdata (loads and fetches only; stores leave d_rdata unchanged), drop cyc/stb, go to DONE with err=0.
  - Counter reaches TIMEOUT-1 with no ack: drop cyc/stb, go to DONE with err=1, rdata=0.
- DONE:
  - Pulse the owning requester's ack for one cycle, err valid alongside it.
  - Return to IDLE.
  - Minimum occupancy: request seen → ack pulse = 3 cycles with ack_in in the first bus cycle. Bus idle gap of ≥2 cycles between transactions.
- if_flush:
  - Flush in BUS_I or DONE-for-fetch: bus access still completes, but if_ack is suppressed and if_rdata is not updated.
  - Flush in IDLE: if_req for that cycle is ignored (no grant).
- ack_in outside BUS_x is ignored.
- Simultaneous ack_in and timeout in the same cycle: ack wins, err=0.

Test Plan:
- Fetch only: if_req, if_addr=0x100, ack_in one cycle after stb → adr=0x100, we=0, sel=F; if_ack pulses 1 cycle later with if_rdata=dat_i (0x00500093), err=0.
- Contention: d_req and if_req held together, every access acked immediately → grant order D,D,D,D,I,D,D,D,D,I… with MAX_D_STREAK=4.
- Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_sel=0011 → bus lines match exactly while cyc=1; d_ack pulses once; d_rdata unchanged.
- Timeout: no ack_in → cyc drops after 16 bus cycles; d_ack=1 with err=1 and d_rdata=0. Ack in the 16th cycle → err=0.
- Flush: if_flush pulsed during BUS_I, ack_in given later → bus cycle completes, no if_ack, if_rdata keeps its old value, next request served normally.
- Reset in BUS_D: rst asserted → cyc=stb=0 and all outputs 0 the next cycle; no d_ack.
